// File: rtl/write_b_merge_pkg.sv
// Shared definitions for the write-response merger: AXI B response codes,
// default widths and the per-leg response accumulation helpers.
package write_b_merge_pkg;

    localparam int unsigned ID_W_DEF  = 4;
    localparam int unsigned LEG_W_DEF = 2;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    // Running merge state of one transaction.
    typedef struct packed {
        logic [1:0] acc;  // worst error code seen so far (OKAY if none)
        logic       exo;  // every leg so far answered EXOKAY
    } merge_t;

    // Fold one more leg response into the running merge state.
    function automatic merge_t merge_resp(input logic [1:0] acc, input logic exo,
                                          input logic [1:0] code);
        merge_t m;
        // Only error codes participate in the max; DECERR dominates SLVERR.
        if (code == DECERR || (code == SLVERR && acc != DECERR)) begin
            m.acc = code;
        end else begin
            m.acc = acc;
        end
        m.exo = exo && (code == EXOKAY);
        return m;
    endfunction

    // Turn the merge state into the single code returned to the master.
    function automatic logic [1:0] resolve_resp(input merge_t m);
        if (m.acc >= SLVERR) begin
            return m.acc;
        end else if (m.exo) begin
            return EXOKAY;
        end else begin
            return OKAY;
        end
    endfunction

endpackage

// File: rtl/write_b_merge_entry.sv
// One slot of the outstanding-write table: ID, expected and received leg
// counts, running merge state and a saturating age.
// With WRITE_B_MERGE_TIMEOUT_EN defined, also an inactivity counter that
// flags the slot once it reaches all-ones.
module write_b_merge_entry
    import write_b_merge_pkg::*;
#(
    parameter int unsigned ID_W  = ID_W_DEF,
    parameter int unsigned LEG_W = LEG_W_DEF
`ifdef WRITE_B_MERGE_TIMEOUT_EN
    ,
    parameter int unsigned TMO_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ID_W-1:0]  load_id,
    input  logic [LEG_W-1:0] load_legs,
    input  logic             age_inc,
    input  logic             leg_acc,
    input  logic [1:0]       leg_resp,
`ifdef WRITE_B_MERGE_TIMEOUT_EN
    input  logic             tmo_done,
    output logic             tmo_expired,
`endif
    output logic             valid,
    output logic [ID_W-1:0]  id,
    output logic [1:0]       age,
    output logic             last_leg,
    output logic [1:0]       final_resp
);

    localparam logic [LEG_W-1:0] LegOne = {{(LEG_W-1){1'b0}}, 1'b1};

    logic             v_q;
    logic [ID_W-1:0]  id_q;
    logic [LEG_W-1:0] legs_q;
    logic [LEG_W-1:0] got_q;
    logic [1:0]       acc_q;
    logic             exo_q;
    logic [1:0]       age_q;
    logic [LEG_W:0]   got_inc;
    merge_t           merged;

    assign got_inc    = {1'b0, got_q} + {{LEG_W{1'b0}}, 1'b1};
    assign last_leg   = (got_inc == {1'b0, legs_q});
    assign merged     = merge_resp(acc_q, exo_q, leg_resp);
    assign final_resp = resolve_resp(merged);
    assign valid      = v_q;
    assign id         = id_q;
    assign age        = age_q;

    // Slot state: load on alloc, fold in legs, free on the final leg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= 1'b0;
            id_q   <= '0;
            legs_q <= '0;
            got_q  <= '0;
            acc_q  <= OKAY;
            exo_q  <= 1'b1;
            age_q  <= 2'd0;
        end else if (load) begin
            v_q    <= 1'b1;
            id_q   <= load_id;
            // A zero leg count is illegal; treat it as a single leg.
            legs_q <= (load_legs == '0) ? LegOne : load_legs;
            got_q  <= '0;
            acc_q  <= OKAY;
            exo_q  <= 1'b1;
            age_q  <= 2'd0;
        end else if (v_q) begin
            if (age_inc && age_q != 2'd3) begin
                age_q <= age_q + 2'd1;
            end
            if (leg_acc) begin
                if (last_leg) begin
                    v_q <= 1'b0;
                end else begin
                    got_q <= got_inc[LEG_W-1:0];
                    acc_q <= merged.acc;
                    exo_q <= merged.exo;
                end
            end
`ifdef WRITE_B_MERGE_TIMEOUT_EN
            if (tmo_done) begin
                v_q <= 1'b0;
            end
`endif
        end
    end

`ifdef WRITE_B_MERGE_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;

    assign tmo_expired = v_q && (&tmo_q);

    // Inactivity counter: restarts on alloc or any leg, holds once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (load || leg_acc) begin
            tmo_q <= '0;
        end else if (v_q && !(&tmo_q)) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`endif

endmodule

// File: rtl/write_b_merge.sv
// Per-master write-response merger. Collects the 1..3 B beats of a split
// write and returns a single merged B beat to the master.
// Optional WRITE_B_MERGE_TIMEOUT_EN: stalled entries complete with SLVERR.
module write_b_merge
    import write_b_merge_pkg::*;
#(
    parameter int unsigned ID_W  = ID_W_DEF,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned LEG_W = LEG_W_DEF
`ifdef WRITE_B_MERGE_TIMEOUT_EN
    ,
    parameter int unsigned TMO_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [ID_W-1:0]  alloc_id,
    input  logic [LEG_W-1:0] alloc_legs,
    output logic             alloc_ready,
    input  logic [ID_W-1:0]  in_bid,
    input  logic [1:0]       in_bresp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ID_W-1:0]  out_bid,
    output logic [1:0]       out_bresp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_unexpected,
    output logic             busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    logic [DEPTH-1:0] ent_v;
    logic [DEPTH-1:0] ent_last;
    logic [DEPTH-1:0] ent_load;
    logic [DEPTH-1:0] ent_age_inc;
    logic [DEPTH-1:0] ent_leg_acc;
    logic [ID_W-1:0]  ent_id   [DEPTH];
    logic [1:0]       ent_age  [DEPTH];
    logic [1:0]       ent_resp [DEPTH];

    logic             alloc_fire;
    idx_t             free_idx;
    logic             hit;
    idx_t             hit_idx;
    logic [1:0]       hit_age;
    logic             out_free;
    logic             in_acc;
    logic             fin_load;

    logic             out_valid_q;
    logic [ID_W-1:0]  out_bid_q;
    logic [1:0]       out_bresp_q;
    logic             err_q;

`ifdef WRITE_B_MERGE_TIMEOUT_EN
    logic [DEPTH-1:0] ent_tmo;
    logic [DEPTH-1:0] ent_tmo_done;
    logic             tmo_found;
    idx_t             tmo_idx;
    logic             tmo_fire;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        write_b_merge_entry #(
            .ID_W  (ID_W),
            .LEG_W (LEG_W)
`ifdef WRITE_B_MERGE_TIMEOUT_EN
            ,
            .TMO_W (TMO_W)
`endif
        ) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (ent_load[g]),
            .load_id    (alloc_id),
            .load_legs  (alloc_legs),
            .age_inc    (ent_age_inc[g]),
            .leg_acc    (ent_leg_acc[g]),
            .leg_resp   (in_bresp),
`ifdef WRITE_B_MERGE_TIMEOUT_EN
            .tmo_done   (ent_tmo_done[g]),
            .tmo_expired(ent_tmo[g]),
`endif
            .valid      (ent_v[g]),
            .id         (ent_id[g]),
            .age        (ent_age[g]),
            .last_leg   (ent_last[g]),
            .final_resp (ent_resp[g])
        );
    end

    // Registered-state-only status: an entry freed this cycle is not visible yet.
    assign alloc_ready = !(&ent_v);
    assign busy        = |ent_v;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Lowest-index free slot.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_v[i]) begin
                free_idx = idx_t'(i);
            end
        end
    end

    // Oldest valid entry matching the incoming ID (ties go to the lowest index).
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_age = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_v[i] && ent_id[i] == in_bid && (!hit || ent_age[i] > hit_age)) begin
                hit     = 1'b1;
                hit_idx = idx_t'(i);
                hit_age = ent_age[i];
            end
        end
    end

    // Only a final leg needs room in the output register; misses are sunk.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !hit || !ent_last[hit_idx] || out_free;
    assign in_acc   = in_valid && in_ready;
    assign fin_load = in_acc && hit && ent_last[hit_idx];

    // Per-slot strobes.
    always_comb begin
        ent_load    = '0;
        ent_age_inc = '0;
        ent_leg_acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_load[i]    = alloc_fire && (free_idx == idx_t'(i));
            ent_age_inc[i] = alloc_fire && ent_v[i];
            ent_leg_acc[i] = in_acc && hit && (hit_idx == idx_t'(i));
        end
    end

`ifdef WRITE_B_MERGE_TIMEOUT_EN
    // Lowest-index expired slot not receiving a leg this cycle.
    always_comb begin
        tmo_found = 1'b0;
        tmo_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_tmo[i] && !ent_leg_acc[i]) begin
                tmo_found = 1'b1;
                tmo_idx   = idx_t'(i);
            end
        end
    end

    // A real final leg wins the output register; the timeout retries next cycle.
    assign tmo_fire = tmo_found && out_free && !fin_load;

    // Free the timed-out slot as its forced beat is loaded.
    always_comb begin
        ent_tmo_done = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_tmo_done[i] = tmo_fire && (tmo_idx == idx_t'(i));
        end
    end
`endif

    // Output register and the miss pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_bid_q   <= '0;
            out_bresp_q <= OKAY;
            err_q       <= 1'b0;
        end else begin
            err_q <= in_valid && !hit;
            if (fin_load) begin
                out_valid_q <= 1'b1;
                out_bid_q   <= in_bid;
                out_bresp_q <= ent_resp[hit_idx];
            end
`ifdef WRITE_B_MERGE_TIMEOUT_EN
            else if (tmo_fire) begin
                out_valid_q <= 1'b1;
                out_bid_q   <= ent_id[tmo_idx];
                out_bresp_q <= SLVERR;
            end
`endif
            else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_bid        = out_bid_q;
    assign out_bresp      = out_bresp_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_write_b_merge.sv
// Directed bench for write_b_merge: a per-cycle vector table plus hand-written
// reset and timeout sequences.
module tb_write_b_merge;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned LEG_W = 2;

    localparam logic [1:0] R_OK  = 2'd0;
    localparam logic [1:0] R_EX  = 2'd1;
    localparam logic [1:0] R_SLV = 2'd2;
    localparam logic [1:0] R_DEC = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_valid;
    logic [ID_W-1:0]  alloc_id;
    logic [LEG_W-1:0] alloc_legs;
    logic             alloc_ready;
    logic [ID_W-1:0]  in_bid;
    logic [1:0]       in_bresp;
    logic             in_valid;
    logic             in_ready;
    logic [ID_W-1:0]  out_bid;
    logic [1:0]       out_bresp;
    logic             out_valid;
    logic             out_ready;
    logic             err_unexpected;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    write_b_merge #(
        .ID_W (ID_W),
        .DEPTH(DEPTH),
        .LEG_W(LEG_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid   (alloc_valid),
        .alloc_id      (alloc_id),
        .alloc_legs    (alloc_legs),
        .alloc_ready   (alloc_ready),
        .in_bid        (in_bid),
        .in_bresp      (in_bresp),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_bid       (out_bid),
        .out_bresp     (out_bresp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err_unexpected(err_unexpected),
        .busy          (busy)
    );

    // Inputs for one cycle, and the outputs expected 1 time unit after they are
    // driven (registered outputs reflect earlier cycles, ready flags this one).
    typedef struct {
        logic       av;
        logic [3:0] aid;
        logic [1:0] alegs;
        logic       iv;
        logic [3:0] ibid;
        logic [1:0] iresp;
        logic       ordy;
        logic       e_ar;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_ob;
        logic [1:0] e_or;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic av, input logic [3:0] aid, input logic [1:0] alegs,
                                 input logic iv, input logic [3:0] ibid, input logic [1:0] iresp,
                                 input logic ordy, input logic ar, input logic ir, input logic ov,
                                 input logic [3:0] ob, input logic [1:0] orr, input logic err,
                                 input logic bsy);
        vec_t v;
        v.av = av; v.aid = aid; v.alegs = alegs;
        v.iv = iv; v.ibid = ibid; v.iresp = iresp; v.ordy = ordy;
        v.e_ar = ar; v.e_ir = ir; v.e_ov = ov; v.e_ob = ob; v.e_or = orr;
        v.e_err = err; v.e_busy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] aid, input logic [1:0] alegs,
                         input logic iv, input logic [3:0] ibid, input logic [1:0] iresp,
                         input logic ordy);
        alloc_valid = av;
        alloc_id    = aid;
        alloc_legs  = alegs;
        in_valid    = iv;
        in_bid      = ibid;
        in_bresp    = iresp;
        out_ready   = ordy;
    endtask

    initial begin
        //           av aid  lg iv bid  resp  rdy ar ir ov ob   or    er bsy
        // single leg
        tbl.push_back(row(1, 5,  1, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 0
        tbl.push_back(row(0, 0,  0, 1, 5,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 5,  R_OK,  0, 0));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0));
        // three legs OKAY, SLVERR, OKAY -> one SLVERR beat
        tbl.push_back(row(1, 3,  3, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 4
        tbl.push_back(row(0, 0,  0, 1, 3,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 3,  R_SLV, 1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 3,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 3,  R_SLV, 0, 0));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0));
        // EXOKAY + EXOKAY -> EXOKAY
        tbl.push_back(row(1, 1,  2, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 10
        tbl.push_back(row(0, 0,  0, 1, 1,  R_EX,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 1,  R_EX,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 1,  R_EX,  0, 0));
        // EXOKAY + OKAY -> OKAY
        tbl.push_back(row(1, 1,  2, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 14
        tbl.push_back(row(0, 0,  0, 1, 1,  R_EX,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 1,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 1,  R_OK,  0, 0));
        // miss: accepted, one-cycle error pulse, no beat
        tbl.push_back(row(0, 0,  0, 1, 9,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 18
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  1, 0));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0));
        // duplicate id 7 (older needs 2 legs), full table, in-order completion
        tbl.push_back(row(1, 7,  2, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 21
        tbl.push_back(row(1, 7,  1, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(1, 2,  1, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(1, 4,  1, 1, 7,  R_SLV, 1, 0, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 7,  R_OK,  1, 0, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 7,  R_EX,  1, 1, 1, 1, 7,  R_SLV, 0, 1));
        tbl.push_back(row(0, 0,  0, 1, 2,  R_OK,  1, 1, 1, 1, 7,  R_EX,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 2,  R_OK,  0, 0));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0));
        // backpressure on the output register
        tbl.push_back(row(1, 6,  1, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 30
        tbl.push_back(row(1, 8,  1, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 6,  R_OK,  0, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 8,  R_SLV, 0, 1, 0, 1, 6,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 8,  R_SLV, 0, 1, 0, 1, 6,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 8,  R_SLV, 1, 1, 1, 1, 6,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 8,  R_SLV, 0, 0));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0));
        // re-alloc of an id completing in the same cycle
        tbl.push_back(row(1, 5,  1, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 38
        tbl.push_back(row(1, 5,  1, 1, 5,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 5,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 1, 5,  R_EX,  1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 5,  R_EX,  0, 0));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0));
        // legs==0 behaves as one leg; DECERR propagates
        tbl.push_back(row(1, 11, 0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0)); // 44
        tbl.push_back(row(0, 0,  0, 1, 11, R_DEC, 1, 1, 1, 0, 0,  R_OK,  0, 1));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 1, 11, R_DEC, 0, 0));
        tbl.push_back(row(0, 0,  0, 0, 0,  R_OK,  1, 1, 1, 0, 0,  R_OK,  0, 0));

        // Reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, R_OK, 1);
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'(0));
        check("reset out_bid", 32'(out_bid), 32'(0));
        check("reset out_bresp", 32'(out_bresp), 32'(0));
        check("reset err_unexpected", 32'(err_unexpected), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset alloc_ready", 32'(alloc_ready), 32'(1));
        rst_n = 1'b1;

        // Table
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].aid, tbl[i].alegs, tbl[i].iv, tbl[i].ibid, tbl[i].iresp,
                  tbl[i].ordy);
            #1;
            check($sformatf("row%0d alloc_ready", i), 32'(alloc_ready), 32'(tbl[i].e_ar));
            check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                check($sformatf("row%0d out_bid", i), 32'(out_bid), 32'(tbl[i].e_ob));
                check($sformatf("row%0d out_bresp", i), 32'(out_bresp), 32'(tbl[i].e_or));
            end
            check($sformatf("row%0d err_unexpected", i), 32'(err_unexpected), 32'(tbl[i].e_err));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // Reset mid-operation discards a pending merge and a held output beat
        @(negedge clk); drive(1, 12, 2, 0, 0, R_OK, 0);
        @(negedge clk); drive(1, 13, 1, 0, 0, R_OK, 0);
        @(negedge clk); drive(0, 0, 0, 1, 13, R_OK, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, R_OK, 0);
        #1;
        check("pre-reset out_valid", 32'(out_valid), 32'(1));
        check("pre-reset out_bid", 32'(out_bid), 32'(13));
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 32'(out_valid), 32'(0));
        check("mid reset out_bid", 32'(out_bid), 32'(0));
        check("mid reset busy", 32'(busy), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        drive(0, 0, 0, 1, 12, R_OK, 1);
        #1;
        check("post-reset stale leg in_ready", 32'(in_ready), 32'(1));
        @(negedge clk); drive(0, 0, 0, 0, 0, R_OK, 1);
        #1;
        check("post-reset stale leg err", 32'(err_unexpected), 32'(1));
        check("post-reset stale leg no beat", 32'(out_valid), 32'(0));

`ifdef WRITE_B_MERGE_TIMEOUT_EN
        // Timeout: one of two legs, then silence -> forced SLVERR beat
        begin
            int  waited;
            logic seen;
            seen   = 1'b0;
            waited = 0;
            @(negedge clk); drive(1, 14, 2, 0, 0, R_OK, 1);
            @(negedge clk); drive(0, 0, 0, 1, 14, R_OK, 1);
            @(negedge clk); drive(0, 0, 0, 0, 0, R_OK, 1);
            for (int c = 0; c < 300 && !seen; c++) begin
                #1;
                if (out_valid) begin
                    seen = 1'b1;
                end else begin
                    waited++;
                    @(negedge clk);
                end
            end
            check("timeout beat seen", 32'(seen), 32'(1));
            check("timeout latency in range", 32'(waited >= 250 && waited <= 260), 32'(1));
            check("timeout out_bid", 32'(out_bid), 32'(14));
            check("timeout out_bresp", 32'(out_bresp), 32'(R_SLV));
            @(negedge clk); drive(0, 0, 0, 1, 14, R_OK, 1);
            @(negedge clk); drive(0, 0, 0, 0, 0, R_OK, 1);
            #1;
            check("late leg after timeout err", 32'(err_unexpected), 32'(1));
            check("late leg after timeout no beat", 32'(out_valid), 32'(0));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
